// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, waits out the one-cycle memory
// latency and hands each word to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int unsigned MEM_BYTES = 80,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_dir,
  input  logic [31:0] mem_inst,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam logic [31:0] LastWord = 32'(MEM_BYTES - 4);

  typedef enum logic [2:0] {
    Idle,
    Issue,
    Resp,
    Valid,
    Done,
    Fault
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instPc_q, instPc_d;
  logic        instValid_q, instValid_d;

  logic        busyState;
  logic [31:0] nextPc;
  logic        redirectBad;

  assign busyState   = (state_q == Issue) || (state_q == Resp) || (state_q == Valid);
  assign nextPc      = pc_q + 32'd4;
  assign redirectBad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LastWord);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= Idle;
      pc_q        <= RESET_PC;
      inst_q      <= 32'd0;
      instPc_q    <= 32'd0;
      instValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      instPc_q    <= instPc_d;
      instValid_q <= instValid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    instPc_d    = instPc_q;
    instValid_d = instValid_q;
    // A redirect beats everything, including a same-cycle handshake or RESP capture.
    if (busyState && redirect_valid) begin
      instValid_d = 1'b0;
      pc_d        = redirect_pc;
      state_d     = redirectBad ? Fault : Issue;
    end else begin
      case (state_q)
        Idle, Done: begin
          if (start) begin
            pc_d    = RESET_PC;
            state_d = Issue;
          end
        end
        Issue: state_d = Resp;
        Resp: begin
          inst_d      = mem_inst;
          instPc_d    = pc_q;
          instValid_d = 1'b1;
          state_d     = Valid;
        end
        Valid: begin
          if (inst_ready) begin
            instValid_d = 1'b0;
            if (nextPc > LastWord) begin
              state_d = Done;
            end else begin
              pc_d    = nextPc;
              state_d = Issue;
            end
          end
        end
        Fault: state_d = Fault;
        default: state_d = Idle;
      endcase
    end
  end

  always_comb begin
    busy  = busyState;
    done  = (state_q == Done);
    fault = (state_q == Fault);
  end

  assign mem_dir    = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = instPc_q;
  assign inst_valid = instValid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner sequences and a
// randomized run against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;

  localparam int          MemBytes = 80;
  localparam logic [31:0] LastWord = 32'd76;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_dir;
  logic [31:0] mem_inst;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        busy;
  logic        done;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [7:0] memBytes [MemBytes];

  bit          running;
  bit          everStarted;
  logic [31:0] expPc;

  typedef struct {
    logic        start;
    logic        rv;
    logic [31:0] rpc;
    logic        ready;
    logic        expValid;
    logic [31:0] expInst;
    logic [31:0] expPc;
    logic        expBusy;
    logic        expDone;
    logic [31:0] expDir;
  } vec_t;

  vec_t vecs [16];

  fetch_sequencer #(.MEM_BYTES(MemBytes), .RESET_PC(32'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_dir       (mem_dir),
    .mem_inst      (mem_inst),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .busy          (busy),
    .done          (done),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big-endian word view of the byte memory; out-of-range reads return zero.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [6:0] i;
    if (a > LastWord) return 32'd0;
    i = a[6:0];
    return {memBytes[i], memBytes[i + 7'd1], memBytes[i + 7'd2], memBytes[i + 7'd3]};
  endfunction

  always @(posedge clk) mem_inst <= memWord(mem_dir);

  function automatic vec_t mkVec(input logic s, input logic r, input logic [31:0] rp,
                                 input logic rdy, input logic ev, input logic [31:0] ei,
                                 input logic [31:0] ep, input logic eb, input logic ed,
                                 input logic [31:0] edir);
    vec_t v;
    v.start = s; v.rv = r; v.rpc = rp; v.ready = rdy;
    v.expValid = ev; v.expInst = ei; v.expPc = ep;
    v.expBusy = eb; v.expDone = ed; v.expDir = edir;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
    start          = s;
    redirect_valid = r;
    redirect_pc    = rp;
    inst_ready     = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitValid(input string name, input int maxCycles);
    for (int i = 0; i < maxCycles && !inst_valid; i++) tick();
    checkOutput(name, {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic checkModel();
    checkOutput("model busy", {31'd0, busy}, {31'd0, running});
    checkOutput("model done", {31'd0, done}, {31'd0, everStarted && !running});
    if (!running) checkOutput("model idle valid", {31'd0, inst_valid}, 32'd0);
    else if (inst_valid) begin
      checkOutput("model inst_pc", inst_pc, expPc);
      checkOutput("model inst", inst, memWord(expPc));
    end
  endtask

  // Advances the model across one edge given the inputs driven for it.
  task automatic modelStep(input logic s, input logic r, input logic [31:0] rp, input logic hs);
    if (running) begin
      if (r) expPc = rp;
      else if (hs) begin
        if (expPc == LastWord) running = 1'b0;
        else expPc = expPc + 32'd4;
      end
    end else if (s) begin
      running     = 1'b1;
      everStarted = 1'b1;
      expPc       = 32'd0;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    int n;
    logic s, r, rdy, hs;
    logic [31:0] rp;

    for (int i = 0; i < MemBytes / 4; i++) begin
      case (i)
        0: w = 32'h20080005;
        1: w = 32'h20090003;
        2: w = 32'h01095020;
        default: w = 32'hA0000000 + 32'(i) * 32'h00010101;
      endcase
      memBytes[4*i]     = w[31:24];
      memBytes[4*i + 1] = w[23:16];
      memBytes[4*i + 2] = w[15:8];
      memBytes[4*i + 3] = w[7:0];
    end

    vecs[0]  = mkVec(1, 0, 0, 1, 0, 0,            0, 1, 0, 0);
    vecs[1]  = mkVec(0, 0, 0, 1, 0, 0,            0, 1, 0, 0);
    vecs[2]  = mkVec(0, 0, 0, 1, 1, 32'h20080005, 0, 1, 0, 0);
    vecs[3]  = mkVec(0, 0, 0, 1, 0, 0,            0, 1, 0, 4);
    vecs[4]  = mkVec(0, 0, 0, 1, 0, 0,            0, 1, 0, 4);
    vecs[5]  = mkVec(0, 0, 0, 0, 1, 32'h20090003, 4, 1, 0, 4);
    for (int i = 6; i <= 10; i++)
      vecs[i] = mkVec(0, 0, 0, 0, 1, 32'h20090003, 4, 1, 0, 4);
    vecs[11] = mkVec(0, 0, 0, 1, 0, 0,            0, 1, 0, 8);
    vecs[12] = mkVec(0, 0, 0, 0, 0, 0,            0, 1, 0, 8);
    vecs[13] = mkVec(0, 0, 0, 0, 1, 32'h01095020, 8, 1, 0, 8);
    vecs[14] = mkVec(1, 0, 0, 0, 1, 32'h01095020, 8, 1, 0, 8);
    vecs[15] = mkVec(0, 0, 0, 1, 0, 0,            0, 1, 0, 12);

    doReset();
    checkOutput("reset inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("reset inst", inst, 32'd0);
    checkOutput("reset inst_pc", inst_pc, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset fault", {31'd0, fault}, 32'd0);
    checkOutput("reset mem_dir", mem_dir, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
    tick(); tick(); tick();
    checkOutput("idle busy", {31'd0, busy}, 32'd0);
    checkOutput("idle mem_dir", mem_dir, 32'd0);

    // Table: normal fetch, backpressure, start-while-busy.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].start, vecs[i].rv, vecs[i].rpc, vecs[i].ready);
      tick();
      checkOutput($sformatf("vec%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].expBusy});
      checkOutput($sformatf("vec%0d done", i), {31'd0, done}, {31'd0, vecs[i].expDone});
      checkOutput($sformatf("vec%0d mem_dir", i), mem_dir, vecs[i].expDir);
      checkOutput($sformatf("vec%0d fault", i), {31'd0, fault}, 32'd0);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d inst", i), inst, vecs[i].expInst);
        checkOutput($sformatf("vec%0d inst_pc", i), inst_pc, vecs[i].expPc);
      end
    end

    // Redirect while in RESP for PC=4, then reset mid-fetch.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("redir pre mem_dir", mem_dir, 32'd4);
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
    tick();
    checkOutput("redir mem_dir", mem_dir, 32'h10);
    checkOutput("redir inst_valid", {31'd0, inst_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    waitValid("redir wait valid", 6);
    checkOutput("redir inst_pc", inst_pc, 32'h10);
    checkOutput("redir inst", inst, memWord(32'h10));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midreset inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("midreset inst", inst, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset mem_dir", mem_dir, 32'd0);

    // Full program run to DONE, then restart.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    n = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (inst_valid) begin
        checkOutput($sformatf("run%0d inst_pc", n), inst_pc, 32'(4 * n));
        checkOutput($sformatf("run%0d inst", n), inst, memWord(32'(4 * n)));
        n++;
      end
      tick();
    end
    checkOutput("run words", 32'(n), 32'd20);
    checkOutput("run done", {31'd0, done}, 32'd1);
    checkOutput("run busy", {31'd0, busy}, 32'd0);
    checkOutput("run inst_valid", {31'd0, inst_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    tick();
    checkOutput("restart done", {31'd0, done}, 32'd0);
    checkOutput("restart busy", {31'd0, busy}, 32'd1);
    checkOutput("restart mem_dir", mem_dir, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    waitValid("restart wait valid", 6);
    checkOutput("restart inst_pc", inst_pc, 32'd0);
    checkOutput("restart inst", inst, 32'h20080005);

    // Faults: misaligned target, then out-of-range target with same-cycle handshake.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h06, 1'b0);
    tick();
    checkOutput("fault06 fault", {31'd0, fault}, 32'd1);
    checkOutput("fault06 mem_dir", mem_dir, 32'h06);
    checkOutput("fault06 busy", {31'd0, busy}, 32'd0);
    checkOutput("fault06 inst_valid", {31'd0, inst_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'd0, 1'b1);
    tick(); tick();
    checkOutput("fault sticky", {31'd0, fault}, 32'd1);
    checkOutput("fault sticky mem_dir", mem_dir, 32'h06);
    doReset();
    checkOutput("fault cleared", {31'd0, fault}, 32'd0);
    checkOutput("fault cleared mem_dir", mem_dir, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    tick(); tick();
    applyStimulus(1'b0, 1'b1, 32'h50, 1'b1);
    tick();
    checkOutput("fault50 fault", {31'd0, fault}, 32'd1);
    checkOutput("fault50 mem_dir", mem_dir, 32'h50);
    checkOutput("fault50 inst_valid", {31'd0, inst_valid}, 32'd0);
    doReset();
    checkOutput("fault50 cleared", {31'd0, fault}, 32'd0);

    // Randomized run against the fetch-stream model.
    doReset();
    running = 1'b0;
    everStarted = 1'b0;
    expPc = 32'd0;
    for (int c = 0; c < 1500; c++) begin
      checkModel();
      s   = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 19) == 0);
      rp  = 32'($urandom_range(0, 19)) * 32'd4;
      rdy = ($urandom_range(0, 2) != 0);
      applyStimulus(s, r, rp, rdy);
      hs = inst_valid && rdy;
      modelStep(s, r, rp, hs);
      tick();
    end
    for (int c = 0; c < 200; c++) begin
      checkModel();
      s = (c == 0);
      applyStimulus(s, 1'b0, 32'd0, 1'b1);
      hs = inst_valid;
      modelStep(s, 1'b0, 32'd0, hs);
      tick();
      if (!running) break;
    end
    checkModel();
    checkOutput("drain done", {31'd0, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
